alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width and the number of iterate cycles for MUL/DIVU.
REQ-002 SHALL have parameter DIV_EN, default 1, meaning DIVU (6'b011011) is a multi-cycle op; when 0, DIVU is decoded as unknown.
REQ-003 SHALL have parameter NOP_CODE, default 6'b111110, meaning the code driven when no op is active.
REQ-004 SHALL have parameter HILO_CODE, default 6'b111111, meaning the code that opens the HiLo register write.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port Signal, input, 6, the funct code of the offered op.
REQ-008 SHALL have port valid, input, 1, meaning Signal is offered this cycle.
REQ-009 SHALL have port flush, input, 1, meaning abort any op in progress.
REQ-010 SHALL have port ready, output, 1, meaning an offered op is accepted this cycle.
REQ-011 SHALL have port busy, output, 1, meaning a multi-cycle op is in progress.
REQ-012 SHALL have port hilo_we, output, 1, a one-cycle HiLo write strobe.
REQ-013 SHALL have ports SignaltoALU, SignaltoSHT, SignaltoMUL and SignaltoMUX, each output, 6, the registered op code, all four always carrying an identical value.

Function
REQ-014 SHALL implement states IDLE, MULT, DIVI and WRHL; ready SHALL be 1 only in IDLE, and busy SHALL be 1 in MULT, DIVI and WRHL.
REQ-015 SHALL accept an op on a rising edge where valid=1, ready=1 and flush=0; all other edges SHALL transfer nothing.
REQ-016 SHALL treat AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MFHI 010000 and MFLO 010010 as single-cycle ops: on accept the op outputs take Signal at that edge (1-cycle latency) and the state stays IDLE.
REQ-017 SHALL, in IDLE with no accepted op, drive NOP_CODE on the op outputs from the next edge.
REQ-018 SHALL treat any accepted code not in REQ-016, and not MUL 011001 or an enabled DIVU, as unknown: op outputs = NOP_CODE, state stays IDLE.
REQ-019 SHALL, on accept of MUL (or DIVU with DIV_EN=1), drive that code on the op outputs, clear the counter to 0, and enter MULT (or DIVI).
REQ-020 SHALL, in MULT/DIVI, increment the counter each edge and hold the op code; at the edge where counter == WIDTH-1 it SHALL enter WRHL, so the op code is visible for exactly WIDTH cycles.
REQ-021 SHALL, in WRHL, drive HILO_CODE with hilo_we=1 for exactly one cycle, then return to IDLE with op outputs = NOP_CODE unless a new op is accepted.
REQ-022 SHALL size the counter to clog2(WIDTH)+1 bits; it SHALL never wrap while in MULT/DIVI.
REQ-023 SHALL ignore valid while busy; Signal changes during MULT/DIVI SHALL NOT affect the outputs or the counter.
REQ-024 SHALL, on flush=1 in any state, go to IDLE at that edge with op outputs = NOP_CODE, hilo_we=0 and counter=0, suppressing WRHL; flush SHALL take priority over valid.
REQ-025 SHALL support WIDTH >= 2; the earliest next accept after a multi-cycle accept at edge 0 is edge WIDTH+1.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state=IDLE, counter=0, op outputs=NOP_CODE, hilo_we=0, busy=0 and ready=1; reset SHALL take priority over flush and valid.
REQ-027 SHALL, when reset is asserted mid-MULT/DIVI, abandon the op with no hilo_we pulse.

Verification
REQ-028 Bench SHALL cover: reset, then ADD offered at edge 1 -> all op outputs = 100000 after edge 1; NOP_CODE after edge 2 when valid=0.
REQ-029 Bench SHALL cover: WIDTH=8, MUL accepted at edge 0 -> op outputs = 011001 for 8 cycles, then 111111 with hilo_we=1 for 1 cycle, and ready=1 after edge 9.
REQ-030 Bench SHALL cover: WIDTH=8, DIVU accepted with DIV_EN=1 -> same timing with code 011011; with DIV_EN=0 -> NOP_CODE, busy stays 0.
REQ-031 Bench SHALL cover: MUL in progress with valid=1 and SUB on every cycle -> no SUB is accepted until IDLE, and the SUB is accepted at edge WIDTH+1.
REQ-032 Bench SHALL cover: flush at counter=3 during MULT -> IDLE next edge, no hilo_we pulse; flush and valid together in IDLE -> op not accepted.
REQ-033 Bench SHALL cover: reset asserted at counter=5 -> all outputs at their reset values after that edge, and the unknown code 111000 is then decoded to NOP_CODE.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Op sequencer that fans a registered ALU op code to four units. It runs
// MUL/DIVU for WIDTH cycles and then issues a one-cycle HiLo write strobe.
module alu_op_sequencer #(
  parameter int         WIDTH     = 32,
  parameter bit         DIV_EN    = 1'b1,
  parameter logic [5:0] NOP_CODE  = 6'b111110,
  parameter logic [5:0] HILO_CODE = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Signal,
  input  logic       valid,
  input  logic       flush,
  output logic       ready,
  output logic       busy,
  output logic       hilo_we,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMUL,
  output logic [5:0] SignaltoMUX
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_MUL  = 6'b011001;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  typedef enum logic [1:0] {IDLE, MULT, DIVI, WRHL} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx, cnt_inc;
  logic [5:0]      op, op_nx;
  logic            we, we_nx;

  assign cnt_inc = cnt + CNT_ONE;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op;
    we_nx    = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = CNT_ZERO;
      op_nx    = NOP_CODE;
    end else begin
      case (state)
        IDLE: begin
          op_nx = NOP_CODE;
          if (valid) begin
            case (Signal)
              OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MFHI, OP_MFLO: begin
                op_nx = Signal;
              end
              OP_MUL: begin
                op_nx    = Signal;
                cnt_nx   = CNT_ZERO;
                state_nx = MULT;
              end
              OP_DIVU: begin
                if (DIV_EN) begin
                  op_nx    = Signal;
                  cnt_nx   = CNT_ZERO;
                  state_nx = DIVI;
                end else begin
                  op_nx = NOP_CODE;
                end
              end
              default: op_nx = NOP_CODE;
            endcase
          end else begin
            op_nx = NOP_CODE;
          end
        end
        MULT, DIVI: begin
          // Leaving on the count that reaches WIDTH-1 keeps the op code up for WIDTH cycles
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_nx = WRHL;
          end else begin
            state_nx = state;
          end
        end
        WRHL: begin
          op_nx    = HILO_CODE;
          we_nx    = 1'b1;
          cnt_nx   = CNT_ZERO;
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = CNT_ZERO;
          op_nx    = NOP_CODE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      op    <= NOP_CODE;
      we    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
      we    <= we_nx;
    end
  end

  assign ready       = (state == IDLE);
  assign busy        = (state != IDLE);
  assign hilo_we     = we;
  assign SignaltoALU = op;
  assign SignaltoSHT = op;
  assign SignaltoMUL = op;
  assign SignaltoMUX = op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with WIDTH=8; a second instance with
// DIV_EN=0 shares the stimulus and is checked on the DIVU case.
module tb_alu_op_sequencer;

  localparam logic [5:0] NOP  = 6'b111110;
  localparam logic [5:0] HILO = 6'b111111;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] MUL  = 6'b011001;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] SRL  = 6'b000010;

  logic       clk = 1'b0;
  logic       reset, valid, flush;
  logic [5:0] Signal;
  logic       ready, busy, hilo_we;
  logic [5:0] alu, sht, mul, mux;
  logic       ready1, busy1, hilo_we1;
  logic [5:0] alu1, sht1, mul1, mux1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Signal(Signal), .valid(valid), .flush(flush),
    .ready(ready), .busy(busy), .hilo_we(hilo_we),
    .SignaltoALU(alu), .SignaltoSHT(sht), .SignaltoMUL(mul), .SignaltoMUX(mux)
  );

  alu_op_sequencer #(.WIDTH(8), .DIV_EN(1'b0)) dut_nodiv (
    .clk(clk), .reset(reset), .Signal(Signal), .valid(valid), .flush(flush),
    .ready(ready1), .busy(busy1), .hilo_we(hilo_we1),
    .SignaltoALU(alu1), .SignaltoSHT(sht1), .SignaltoMUL(mul1), .SignaltoMUX(mux1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] op, input logic rdy,
                     input logic bsy, input logic we);
    check({tag, ".op"},    32'({alu, sht, mul, mux}), 32'({op, op, op, op}));
    check({tag, ".ready"}, 32'(ready),   32'(rdy));
    check({tag, ".busy"},  32'(busy),    32'(bsy));
    check({tag, ".we"},    32'(hilo_we), 32'(we));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a multi-cycle op at edge 0 and follow it through edge 9
  task automatic run_multi(input string tag, input logic [5:0] code, input logic keep_sub);
    Signal = code; valid = 1'b1;
    tick();
    chk({tag, ".e0"}, code, 1'b0, 1'b1, 1'b0);
    if (keep_sub) begin
      Signal = SUB; valid = 1'b1;
    end else begin
      valid = 1'b0;
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("%s.e%0d", tag, k), code, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk({tag, ".e8"}, HILO, 1'b1, 1'b0, 1'b1);
    tick();
    chk({tag, ".e9"}, keep_sub ? SUB : NOP, 1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    tick();
    chk({tag, ".e10"}, NOP, 1'b1, 1'b0, 1'b0);
  endtask

  logic [5:0] singles [6] = '{6'b100100, 6'b100101, 6'b101010, 6'b000010, 6'b010000, 6'b010010};

  initial begin
    reset = 1'b1; valid = 1'b0; flush = 1'b0; Signal = 6'b000000;
    tick(); tick();
    chk("reset", NOP, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    Signal = ADD; valid = 1'b1;
    tick();
    chk("add", ADD, 1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    tick();
    chk("add_idle", NOP, 1'b1, 1'b0, 1'b0);

    foreach (singles[i]) begin
      Signal = singles[i]; valid = 1'b1;
      tick();
      chk($sformatf("single%0d", i), singles[i], 1'b1, 1'b0, 1'b0);
    end
    Signal = 6'b000111;
    tick();
    chk("unknown", NOP, 1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    tick();

    run_multi("mul", MUL, 1'b0);

    Signal = DIVU; valid = 1'b1;
    tick();
    check("nodiv.op", 32'(alu1), 32'(NOP));
    check("nodiv.busy0", 32'(busy1), 32'(1'b0));
    chk("divu.e0", DIVU, 1'b0, 1'b1, 1'b0);
    valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("divu.e%0d", k), DIVU, 1'b0, 1'b1, 1'b0);
      check($sformatf("nodiv.busy%0d", k), 32'(busy1), 32'(1'b0));
    end
    tick();
    chk("divu.e8", HILO, 1'b1, 1'b0, 1'b1);
    check("nodiv.we", 32'(hilo_we1), 32'(1'b0));
    tick();
    chk("divu.e9", NOP, 1'b1, 1'b0, 1'b0);

    run_multi("mulsub", MUL, 1'b1);

    // Flush after the counter reaches 3
    Signal = MUL; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    chk("flush", NOP, 1'b1, 1'b0, 1'b0);
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("flush.after%0d", k), NOP, 1'b1, 1'b0, 1'b0);
    end
    Signal = ADD; valid = 1'b1; flush = 1'b1;
    tick();
    chk("flush_valid", NOP, 1'b1, 1'b0, 1'b0);
    flush = 1'b0; valid = 1'b0;
    tick();

    // Reset after the counter reaches 5, with valid and flush also high
    Signal = MUL; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_reset", MUL, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; valid = 1'b1; flush = 1'b1; Signal = ADD;
    tick();
    chk("mid_reset", NOP, 1'b1, 1'b0, 1'b0);
    reset = 1'b0; valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("reset.after%0d", k), NOP, 1'b1, 1'b0, 1'b0);
    end
    Signal = 6'b111000; valid = 1'b1;
    tick();
    chk("unk_111000", NOP, 1'b1, 1'b0, 1'b0);
    Signal = SRL;
    tick();
    chk("srl", SRL, 1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
